// File: rtl/freq_meter_if.sv
// Control/result bundle between freq_meter (slave) and its host (master).
// Width of the freq result follows CNT_W of the attached meter.
interface freq_meter_if #(
  parameter int CNT_W = 27
);
  logic             start;
  logic             continuous;
  logic             busy;
  logic             valid;
  logic             overflow;
  logic [CNT_W-1:0] freq;

  modport master (
    output start, continuous,
    input  busy, freq, valid, overflow
  );

  modport slave (
    input  start, continuous,
    output busy, freq, valid, overflow
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of async sig_in over GATE_CYCLES clk cycles.
// Optional macro FREQ_METER_DEGLITCH_EN inserts a 2-cycle level filter after the synchronizer.
module freq_meter #(
  parameter int GATE_CYCLES = 125000000,
  parameter int CNT_W       = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic             w_rise;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_freq;
  logic             r_overflow;
  logic             w_gate_last;
  logic             w_sat;
  logic [CNT_W-1:0] w_edge_nxt;
  logic             w_ovf_nxt;
  logic             w_clear;
  logic             w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

`ifdef FREQ_METER_DEGLITCH_EN
  logic r_f, r_f_prev;

  // r_s3 is s2 one cycle ago, so equality means s2 has held for two cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f      <= 1'b0;
      r_f_prev <= 1'b0;
    end else begin
      if (r_s2 == r_s3) r_f <= r_s2;
      r_f_prev <= r_f;
    end
  end

  assign w_rise = r_f & ~r_f_prev;
`else
  assign w_rise = r_s2 & ~r_s3;
`endif

  assign w_gate_last = (r_gate_cnt == GATE_LAST);
  assign w_sat       = (r_edge_cnt == CNT_MAX);
  assign w_edge_nxt  = (w_rise && !w_sat) ? r_edge_cnt + 1'b1 : r_edge_cnt;
  assign w_ovf_nxt   = r_ovf | (w_rise & w_sat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start || bus.continuous) begin
          w_state_nxt = GATE;
          w_clear     = 1'b1;
        end
      end
      GATE: begin
        if (w_gate_last) begin
          w_state_nxt = LATCH;
          w_load      = 1'b1;
        end
      end
      LATCH: begin
        if (bus.continuous) begin
          w_state_nxt = GATE;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (w_clear) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (r_state == GATE) begin
      if (!w_gate_last) r_gate_cnt <= r_gate_cnt + 1'b1;
      r_edge_cnt <= w_edge_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // Result is loaded on the edge entering LATCH (including the final gate
  // cycle's rise) so freq/overflow are already new while valid is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_freq     <= '0;
      r_overflow <= 1'b0;
    end else if (w_load) begin
      r_freq     <= w_edge_nxt;
      r_overflow <= w_ovf_nxt;
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.valid    = (r_state == LATCH);
  assign bus.freq     = r_freq;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two meters (CNT_W=8 and CNT_W=4) share sig_in and
// control; every valid pulse is compared against a sample-history reference model.
module tb_freq_meter;

  localparam int G     = 100;
  localparam int MAXA  = 255;
  localparam int MAXB  = 15;
  localparam int MAXC  = 16384;
`ifdef FREQ_METER_DEGLITCH_EN
  localparam int DLY   = 2;
  localparam bit DG    = 1'b1;
`else
  localparam int DLY   = 1;
  localparam bit DG    = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic sig_in;

  freq_meter_if #(.CNT_W(8)) ifa ();
  freq_meter_if #(.CNT_W(4)) ifb ();

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(ifa.slave)
  );
  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in), .bus(ifb.slave)
  );

  always #4 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Stimulus generator: sig_in changes 1 time unit after each rising clk edge
  int sig_mode = 0;
  int period   = 10;
  int phase    = 0;
  always @(posedge clk) begin
    #1;
    phase++;
    case (sig_mode)
      1:       sig_in = (phase % period) < (period / 2);
      2:       sig_in = 1'($urandom);
      3:       sig_in = ((phase % 10) == 0) || (((phase % 20) >= 5) && ((phase % 20) <= 7));
      default: sig_in = 1'b0;
    endcase
  end

  // Sample history: hist[k] is the level sig_in presents at rising edge k;
  // yh[k] is the level after requiring two equal consecutive samples.
  int cyc = 0;
  bit hist [0:MAXC-1];
  bit yh   [0:MAXC-1];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: observed %0d, expected < %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    hist[cyc] = reset ? 1'b0 : sig_in;
    if (reset)                         yh[cyc] = 1'b0;
    else if (hist[cyc] == hist[cyc-1]) yh[cyc] = hist[cyc];
    else                               yh[cyc] = yh[cyc-1];
  end

  function automatic bit lvl(input int k);
    if (k < 0) return 1'b0;
    return DG ? yh[k] : hist[k];
  endfunction

  // A gate reported at cycle v covered cycles v-G..v-1; the meter sees each
  // sampled level DLY cycles late.
  function automatic int model_count(input int v);
    int n = 0;
    for (int c = v - G; c <= v - 1; c++)
      if (lvl(c - DLY) && !lvl(c - DLY - 1)) n++;
    return n;
  endfunction

  int n_valid = 0;
  int last_vcyc = 0;
  int vq [$];
  int cnt;
  int hold_fa = 0, hold_oa = 0, hold_fb = 0, hold_ob = 0;

  always @(negedge clk) begin
    if (reset) begin
      hold_fa = 0; hold_oa = 0; hold_fb = 0; hold_ob = 0;
    end else if (ifa.valid || ifb.valid) begin
      cnt = model_count(cyc);
      n_valid++;
      last_vcyc = cyc;
      vq.push_back(cyc);
      hold_fa = (cnt > MAXA) ? MAXA : cnt;
      hold_oa = (cnt > MAXA) ? 1 : 0;
      hold_fb = (cnt > MAXB) ? MAXB : cnt;
      hold_ob = (cnt > MAXB) ? 1 : 0;
      check("validA", 32'(ifa.valid), 1);
      check("validB", 32'(ifb.valid), 1);
      check("freqA",  32'(ifa.freq), hold_fa);
      check("ovfA",   32'(ifa.overflow), hold_oa);
      check("freqB",  32'(ifb.freq), hold_fb);
      check("ovfB",   32'(ifb.overflow), hold_ob);
    end else begin
      check("holdFreqA", 32'(ifa.freq), hold_fa);
      check("holdOvfA",  32'(ifa.overflow), hold_oa);
      check("holdFreqB", 32'(ifb.freq), hold_fb);
      check("holdOvfB",  32'(ifb.overflow), hold_ob);
    end
  end

  function automatic int vq_at(input int i);
    if (i < 0 || i >= vq.size()) return -1;
    return vq[i];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    ifa.start = v;
    ifb.start = v;
  endtask

  task automatic set_cont(input logic v);
    ifa.continuous = v;
    ifb.continuous = v;
  endtask

  // One single-shot gate; e1/e2 are gate-cycle offsets of extra start pulses (0 = none)
  task automatic run_gate(input string tag, input int e1, input int e2);
    int t0, nv0, k;
    nv0 = n_valid;
    t0  = cyc;
    check({tag, "_idle_busy"}, 32'(ifa.busy), 0);
    set_start(1'b1);
    step();
    set_start(1'b0);
    check({tag, "_gate_busy"}, 32'(ifa.busy), 1);
    k = 1;
    while (n_valid == nv0 && k < G + 30) begin
      set_start((k == e1) || (k == e2));
      step();
      k++;
    end
    set_start(1'b0);
    check({tag, "_nvalid"}, n_valid - nv0, 1);
    check({tag, "_latency"}, last_vcyc - t0, G + 1);
    check({tag, "_busy_after"}, 32'(ifa.busy), 0);
  endtask

  int t0, nv0, k;

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    set_start(1'b0);
    set_cont(1'b0);
    repeat (3) step();
    check("rst_busy",  32'(ifa.busy), 0);
    check("rst_valid", 32'(ifa.valid), 0);
    check("rst_freq",  32'(ifa.freq), 0);
    check("rst_ovf",   32'(ifa.overflow), 0);
    reset = 1'b0;
    repeat (5) step();

    // Nominal: period 10 -> 10 edges per gate
    sig_mode = 1; period = 10;
    repeat (20) step();
    run_gate("nominal", 0, 0);
    check("nominal_freq", 32'(ifa.freq), 10);
    check("nominal_ovf",  32'(ifa.overflow), 0);

    // Saturation: period 4 -> 25 edges; the 4-bit meter clips at 15
    period = 4;
    repeat (10) step();
    run_gate("sat", 0, 0);
    check("sat_freqA", 32'(ifa.freq), 25);
    check("sat_freqB", 32'(ifb.freq), 15);
    check("sat_ovfB",  32'(ifb.overflow), 1);
    sig_mode = 0;
    repeat (10) step();
    run_gate("quiet", 0, 0);
    check("quiet_freqB", 32'(ifb.freq), 0);
    check("quiet_ovfB",  32'(ifb.overflow), 0);

    // Continuous: three back-to-back gates, then drop continuous mid-gate
    sig_mode = 1; period = 20;
    repeat (20) step();
    nv0 = n_valid;
    t0  = cyc;
    set_cont(1'b1);
    k = 0;
    while (n_valid < nv0 + 3 && k < 400) begin
      step();
      k++;
    end
    check("cont_n3",    n_valid - nv0, 3);
    check("cont_first", vq_at(nv0) - t0, G + 1);
    check("cont_gap1",  vq_at(nv0 + 1) - vq_at(nv0), G + 1);
    check("cont_gap2",  vq_at(nv0 + 2) - vq_at(nv0 + 1), G + 1);
    check("cont_freq",  32'(ifa.freq), 5);
    repeat (50) step();
    set_cont(1'b0);
    repeat (150) step();
    check("cont_n4",    n_valid - nv0, 4);
    check("cont_gap3",  vq_at(nv0 + 3) - vq_at(nv0 + 2), G + 1);
    check("cont_busy",  32'(ifa.busy), 0);
    check("cont_freq4", 32'(ifa.freq), 5);

    // Start while busy is ignored
    period = 10;
    repeat (10) step();
    nv0 = n_valid;
    run_gate("busy_start", 10, 99);
    repeat (30) step();
    check("busy_start_once", n_valid - nv0, 1);
    check("busy_start_freq", 32'(ifa.freq), 10);

    // Reset mid-gate abandons the measurement
    nv0 = n_valid;
    set_start(1'b1);
    step();
    set_start(1'b0);
    repeat (49) step();
    reset = 1'b1;
    #1;
    check("midrst_busy",  32'(ifa.busy), 0);
    check("midrst_valid", 32'(ifa.valid), 0);
    check("midrst_freq",  32'(ifa.freq), 0);
    check("midrst_ovf",   32'(ifa.overflow), 0);
    step();
    reset = 1'b0;
    repeat (130) step();
    check("midrst_novalid", n_valid - nv0, 0);
    run_gate("after_rst", 0, 0);
    check("after_rst_freq", 32'(ifa.freq), 10);

    // Glitch pattern: 1-clk pulses every 10 plus 3-clk pulses every 20
    sig_mode = 3;
    repeat (30) step();
    run_gate("glitch", 0, 0);
    check("glitch_freq", 32'(ifa.freq), DG ? 5 : 15);

    // Randomized gates against the history model
    for (int i = 0; i < 8; i++) begin
      sig_mode = int'($urandom_range(1, 2));
      period   = int'($urandom_range(2, 12));
      repeat ($urandom_range(0, 15)) step();
      run_gate("rnd", 0, 0);
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
